// File: rtl/if_prefetch.sv
// Instruction fetch prefetch queue: issues word fetches ahead of decode, buffers returned
// instruction words in order, and discards in-flight responses after a redirect.
module if_prefetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [29:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_iw
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = CW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] iw;
    logic        filled;
  } entry_t;

  entry_t          q [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW-1:0]   fill_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   unfilled;
  logic [CW-1:0]   drop;
  logic [29:0]     fetch_word;

  logic            req_ok;
  logic            alloc;
  logic            pop;
  logic            rsp_drop;
  logic            rsp_fill;
  logic            rsp_flushed;
  logic [OW-1:0]   outstanding;

  // Low address bits are architecturally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, redirect_addr[1:0]};

  // Handshake qualification and response routing.
  always_comb begin
    outstanding = OW'(unfilled) + OW'(drop);
    req_ok      = 1'b0;
    alloc       = 1'b0;
    pop         = 1'b0;
    rsp_drop    = 1'b0;
    rsp_fill    = 1'b0;
    rsp_flushed = 1'b0;
    if (!reset) begin
      req_ok = (count != CW'(DEPTH)) && !halt && !redirect_valid &&
               (outstanding < OW'(DEPTH));
    end
    alloc       = req_ok && mem_req_ready;
    pop         = q[head].filled && id_ready;
    rsp_drop    = mem_rsp_valid && (drop != '0);
    rsp_fill    = mem_rsp_valid && (drop == '0) && (unfilled != '0);
    rsp_flushed = mem_rsp_valid && (outstanding != '0);
  end

  assign mem_req_valid = req_ok;
  assign mem_addr      = fetch_word;
  assign id_valid      = q[head].filled;
  assign id_pc         = q[head].pc;
  assign id_iw         = q[head].iw;

  // Queue, pointers, fetch address and drop accounting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      head       <= '0;
      tail       <= '0;
      fill_ptr   <= '0;
      count      <= '0;
      unfilled   <= '0;
      drop       <= '0;
      fetch_word <= PC_RESET[31:2];
    end else if (redirect_valid) begin
      // Every unfilled slot becomes a response to discard; one arriving now is already gone.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i].filled <= 1'b0;
      end
      head       <= tail;
      fill_ptr   <= tail;
      count      <= '0;
      unfilled   <= '0;
      drop       <= drop + unfilled - CW'(rsp_flushed);
      fetch_word <= redirect_addr[31:2];
    end else begin
      if (alloc) begin
        q[tail].pc     <= {fetch_word, 2'b00};
        q[tail].iw     <= '0;
        q[tail].filled <= 1'b0;
        tail           <= tail + AW'(1);
        fetch_word     <= fetch_word + 30'd1;
      end
      if (rsp_fill) begin
        q[fill_ptr].iw     <= mem_rsp_data;
        q[fill_ptr].filled <= 1'b1;
        fill_ptr           <= fill_ptr + AW'(1);
      end
      if (pop) begin
        q[head].filled <= 1'b0;
        head           <= head + AW'(1);
      end
      if (rsp_drop) begin
        drop <= drop - CW'(1);
      end
      count    <= count + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(rsp_fill);
    end
  end

endmodule
